// File: rtl/switch_debounce.sv
// Switch conditioner: per channel, a 2-flop synchroniser followed by a
// qualification counter. Produces a registered clean level plus one-cycle
// rise/fall pulses that line up with the level change.

// One switch channel: synchroniser, debounce FSM, registered level and pulses.
module switch_debounce_ch #(
   parameter int unsigned CNT_W        = 20,
   parameter int unsigned DEBOUNCE_CYC = 1000000
) (
   input  logic clk,
   input  logic rstn,
   input  logic raw,
   output logic db,
   output logic rise,
   output logic fall
);

   typedef enum logic {IDLE, COUNT} state_t;

   // Last count value before the new level is accepted.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             sync1, sync2;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             db_d, rise_d, fall_d;

   // Two plain flops; only sync2 is ever looked at by the FSM.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // FSM state, counter, level and pulse registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         db      <= 1'b0;
         rise    <= 1'b0;
         fall    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         db      <= db_d;
         rise    <= rise_d;
         fall    <= fall_d;
      end
   end

   // Next state: any sample equal to the current level drops back to IDLE,
   // including on the final qualifying cycle, so a bounce always wins.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      db_d    = db;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (sync2 != db) begin
               state_d = COUNT;
               cnt_d   = CNT_W'(1);
            end else begin
               cnt_d   = '0;
            end
         end
         COUNT: begin
            if (sync2 == db) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               db_d    = sync2;
               rise_d  = sync2;
               fall_d  = ~sync2;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// Top: NUM_SW independent channels side by side.
module switch_debounce #(
   parameter int unsigned NUM_SW       = 2,
   parameter int unsigned CNT_W        = 20,
   parameter int unsigned DEBOUNCE_CYC = 1000000
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [NUM_SW-1:0] sw_raw,
   output logic [NUM_SW-1:0] sw_db,
   output logic [NUM_SW-1:0] sw_rise,
   output logic [NUM_SW-1:0] sw_fall
);

   for (genvar g = 0; g < NUM_SW; g++) begin : gen_ch
      switch_debounce_ch #(
         .CNT_W        (CNT_W),
         .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_ch (
         .clk  (clk),
         .rstn (rstn),
         .raw  (sw_raw[g]),
         .db   (sw_db[g]),
         .rise (sw_rise[g]),
         .fall (sw_fall[g])
      );
   end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DEBOUNCE_CYC=4, CNT_W=3, NUM_SW=2.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_switch_debounce;

   logic       clk;
   logic       rstn;
   logic [1:0] sw_raw;
   logic [1:0] sw_db, sw_rise, sw_fall;

   int n_chk  = 0;
   int n_fail = 0;

   switch_debounce #(
      .NUM_SW       (2),
      .CNT_W        (3),
      .DEBOUNCE_CYC (4)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .sw_raw  (sw_raw),
      .sw_db   (sw_db),
      .sw_rise (sw_rise),
      .sw_fall (sw_fall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [1:0] db, input logic [1:0] r,
                          input logic [1:0] f);
      chk({tag, ".db"},   sw_db,   db);
      chk({tag, ".rise"}, sw_rise, r);
      chk({tag, ".fall"}, sw_fall, f);
   endtask

   initial begin
      // Reset held with both switches high: everything stays clear.
      rstn   = 1'b0;
      sw_raw = 2'b11;
      step(3);
      chk_all("rst_hold", 2'b00, 2'b00, 2'b00);

      // Release with switches high: level appears 6 edges after release.
      rstn = 1'b1;
      step(5);
      chk_all("rel_e5", 2'b00, 2'b00, 2'b00);
      step(1);
      chk_all("rel_e6", 2'b11, 2'b11, 2'b00);
      step(1);
      chk_all("rel_e7", 2'b11, 2'b00, 2'b00);

      // Both low again: simultaneous falls.
      sw_raw = 2'b00;
      step(5);
      chk_all("lo_e4", 2'b11, 2'b00, 2'b00);
      step(1);
      chk_all("lo_e5", 2'b00, 2'b00, 2'b11);
      step(1);
      chk_all("lo_e6", 2'b00, 2'b00, 2'b00);

      // Clean step on channel 0, rise then fall.
      sw_raw = 2'b01;
      step(5);
      chk_all("c0r_e4", 2'b00, 2'b00, 2'b00);
      step(1);
      chk_all("c0r_e5", 2'b01, 2'b01, 2'b00);
      step(1);
      chk_all("c0r_e6", 2'b01, 2'b00, 2'b00);
      sw_raw = 2'b00;
      step(5);
      chk_all("c0f_e4", 2'b01, 2'b00, 2'b00);
      step(1);
      chk_all("c0f_e5", 2'b00, 2'b00, 2'b01);
      step(1);
      chk_all("c0f_e6", 2'b00, 2'b00, 2'b00);

      // Bounce on channel 1: high 3, low 1, high 3, low. Each low sample lands
      // on the last qualifying cycle, so nothing may change.
      sw_raw = 2'b10;
      for (int i = 0; i < 3; i++) begin step(1); chk_all("bnc_a", 2'b00, 2'b00, 2'b00); end
      sw_raw = 2'b00;
      step(1); chk_all("bnc_b", 2'b00, 2'b00, 2'b00);
      sw_raw = 2'b10;
      for (int i = 0; i < 3; i++) begin step(1); chk_all("bnc_c", 2'b00, 2'b00, 2'b00); end
      sw_raw = 2'b00;
      for (int i = 0; i < 6; i++) begin step(1); chk_all("bnc_d", 2'b00, 2'b00, 2'b00); end

      // Counter was cleared: a clean step on channel 1 takes the full latency.
      sw_raw = 2'b10;
      step(5);
      chk_all("c1r_e4", 2'b00, 2'b00, 2'b00);
      step(1);
      chk_all("c1r_e5", 2'b10, 2'b10, 2'b00);
      sw_raw = 2'b00;
      step(6);
      chk_all("c1f_e5", 2'b00, 2'b00, 2'b10);

      // Last-cycle bounce on channel 0, then a clean run of 4 samples.
      step(2);
      sw_raw = 2'b01;
      step(3);
      sw_raw = 2'b00;
      step(1);
      sw_raw = 2'b01;
      step(2);
      chk_all("lcb_e5", 2'b00, 2'b00, 2'b00);
      step(3);
      chk_all("lcb_e8", 2'b00, 2'b00, 2'b00);
      step(1);
      chk_all("lcb_e9", 2'b01, 2'b01, 2'b00);
      sw_raw = 2'b00;
      step(7);
      chk_all("lcb_back", 2'b00, 2'b00, 2'b00);

      // Independence: both step on the same edge.
      sw_raw = 2'b11;
      step(5);
      chk_all("ind_e4", 2'b00, 2'b00, 2'b00);
      step(1);
      chk_all("ind_e5", 2'b11, 2'b11, 2'b00);
      step(1);
      chk_all("ind_e6", 2'b11, 2'b00, 2'b00);

      // Reset mid-count: channel 0 heading low, count at 2 after 4 edges.
      sw_raw = 2'b10;
      step(4);
      chk_all("mid_pre", 2'b11, 2'b00, 2'b00);
      #2 rstn = 1'b0;
      #1 chk_all("mid_async", 2'b00, 2'b00, 2'b00);
      step(2);
      chk_all("mid_hold", 2'b00, 2'b00, 2'b00);

      // Release: qualification restarts from scratch.
      rstn   = 1'b1;
      sw_raw = 2'b11;
      step(5);
      chk_all("mid_e5", 2'b00, 2'b00, 2'b00);
      step(1);
      chk_all("mid_e6", 2'b11, 2'b11, 2'b00);
      step(1);
      chk_all("mid_e7", 2'b11, 2'b00, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
